// File: rtl/vcr_ovc_credit_tracker_pkg.sv
// Shared constants and helpers for the output-VC credit tracker.
// Reset-style selectors, error bit positions and the clogb width helper.
package vcr_ovc_credit_tracker_pkg;

    localparam int RESET_TYPE_ASYNC = 0;
    localparam int RESET_TYPE_SYNC  = 1;

    localparam int ERR_UNDERFLOW = 0;
    localparam int ERR_OVERFLOW  = 1;

    // Number of bits needed to encode values 0..value-1.
    function automatic int clogb(input int value);
        int v;
        int bits;
        v    = value - 1;
        bits = 0;
        while (v > 0) begin
            bits = bits + 1;
            v    = v >> 1;
        end
        return (bits < 1) ? 1 : bits;
    endfunction

endpackage

// File: rtl/vcr_ovc_credit_tracker_dff.sv
// Enabled register with selectable async or sync reset to a constant value.
// Holds its value unless active is high on a rising clock edge.
module c_dff
    import vcr_ovc_credit_tracker_pkg::*;
#(
    parameter int              width       = 1,
    parameter int              reset_type  = RESET_TYPE_ASYNC,
    parameter logic [width-1:0] reset_value = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             active,
    input  logic [width-1:0] d,
    output logic [width-1:0] q
);

    logic [width-1:0] state_q;

    generate
        if (reset_type == RESET_TYPE_ASYNC) begin : g_async
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    state_q <= reset_value;
                end else if (active) begin
                    state_q <= d;
                end
            end
        end else begin : g_sync
            always_ff @(posedge clk) begin
                if (reset) begin
                    state_q <= reset_value;
                end else if (active) begin
                    state_q <= d;
                end
            end
        end
    endgenerate

    assign q = state_q;

endmodule

// File: rtl/vcr_ovc_credit_tracker.sv
// Credit counter for one output VC: tracks free downstream buffer entries and
// flags full/empty plus non-sticky underflow/overflow, saturating on error.
module vcr_ovc_credit_tracker
    import vcr_ovc_credit_tracker_pkg::*;
#(
    parameter int buffer_size = 8,
    parameter int reset_type  = RESET_TYPE_ASYNC
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       flit_valid,
    input  logic       flit_sel,
    input  logic       cred_valid,
    output logic       full,
    output logic       full_prev,
    output logic       empty,
    output logic [1:0] errors
);

    localparam int                FREE_W   = clogb(buffer_size + 1);
    localparam logic [FREE_W-1:0] FREE_MAX = FREE_W'(buffer_size);

    logic              debit;
    logic              credit;
    logic              active;
    logic              at_zero;
    logic              at_full;
    logic [FREE_W-1:0] free_q;
    logic [FREE_W-1:0] free_d;

    // Gating with reset keeps errors quiet and inputs ignored while in reset.
    assign debit   = flit_valid & flit_sel & ~reset;
    assign credit  = cred_valid & ~reset;
    assign active  = debit | credit;
    assign at_zero = (free_q == '0);
    assign at_full = (free_q == FREE_MAX);

    always_comb begin
        free_d = free_q;
        if (debit & ~credit & ~at_zero) begin
            free_d = free_q - FREE_W'(1);
        end else if (credit & ~debit & ~at_full) begin
            free_d = free_q + FREE_W'(1);
        end
    end

    c_dff #(
        .width       (FREE_W),
        .reset_type  (reset_type),
        .reset_value (FREE_MAX)
    ) free_reg (
        .clk    (clk),
        .reset  (reset),
        .active (active),
        .d      (free_d),
        .q      (free_q)
    );

    // A same-cycle credit is deliberately ignored here; it lands next cycle.
    assign full_prev = at_zero;
    assign full      = at_zero | ((free_q == FREE_W'(1)) & debit);
    assign empty     = at_full;

    always_comb begin
        errors                = 2'b00;
        errors[ERR_UNDERFLOW] = debit & at_zero;
        errors[ERR_OVERFLOW]  = credit & ~debit & at_full;
    end

endmodule

// File: tb/tb_vcr_ovc_credit_tracker.sv
// Bench for the output-VC credit tracker with buffer_size = 8.
// A reference count predicts outputs per cycle; a queue pairs them with samples.
module tb_vcr_ovc_credit_tracker;

    localparam int BUF = 8;

    logic       clk;
    logic       reset;
    logic       flit_valid;
    logic       flit_sel;
    logic       cred_valid;
    logic       full;
    logic       full_prev;
    logic       empty;
    logic [1:0] errors;

    int n_checks;
    int n_errors;
    int model_free;

    // Entry layout: {free count after reset/before edge [8:5], full, full_prev, empty, errors[1:0]}
    logic [8:0] exp_q[$];

    vcr_ovc_credit_tracker #(.buffer_size(BUF)) dut (
        .clk        (clk),
        .reset      (reset),
        .flit_valid (flit_valid),
        .flit_sel   (flit_sel),
        .cred_valid (cred_valid),
        .full       (full),
        .full_prev  (full_prev),
        .empty      (empty),
        .errors     (errors)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [8:0] predict(input logic fv, input logic fs, input logic cv,
                                           input int free, input logic rst);
        logic d;
        logic c;
        logic f;
        logic fp;
        logic e;
        logic [1:0] er;
        d  = fv & fs & ~rst;
        c  = cv & ~rst;
        fp = (free == 0);
        f  = (free == 0) || ((free == 1) && d);
        e  = (free == BUF);
        er[0] = d && (free == 0);
        er[1] = c && !d && (free == BUF);
        return {4'(free), f, fp, e, er};
    endfunction

    task automatic sample_and_check(input string tag);
        logic [8:0] exp;
        if (exp_q.size() == 0) begin
            check_val({tag, "_queue_empty"}, 16'd1, 16'd0);
        end else begin
            exp = exp_q.pop_front();
            check_val({tag, "_outs"}, {11'd0, full, full_prev, empty, errors}, {11'd0, exp[4:0]});
            check_val({tag, "_free"}, {12'd0, dut.free_q}, {12'd0, exp[8:5]});
        end
    endtask

    // One cycle: drive at negedge, check combinational view, advance model at posedge.
    task automatic drive_cycle(input logic fv, input logic fs, input logic cv, input string tag);
        int d;
        int c;
        @(negedge clk);
        flit_valid = fv;
        flit_sel   = fs;
        cred_valid = cv;
        exp_q.push_back(predict(fv, fs, cv, model_free, 1'b0));
        #1;
        sample_and_check(tag);
        @(posedge clk);
        d = (fv && fs) ? 1 : 0;
        c = cv ? 1 : 0;
        if (d == 1 && c == 0 && model_free > 0) model_free--;
        else if (c == 1 && d == 0 && model_free < BUF) model_free++;
    endtask

    task automatic reset_dut();
        @(negedge clk);
        reset      = 1'b1;
        flit_valid = 1'b0;
        flit_sel   = 1'b0;
        cred_valid = 1'b0;
        repeat (2) @(negedge clk);
        model_free = BUF;
        reset      = 1'b0;
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        model_free = BUF;
        reset      = 1'b0;
        flit_valid = 1'b0;
        flit_sel   = 1'b0;
        cred_valid = 1'b0;

        // Reset value while reset is held, with inputs that must be ignored.
        @(negedge clk);
        reset      = 1'b1;
        cred_valid = 1'b1;
        flit_valid = 1'b1;
        flit_sel   = 1'b1;
        exp_q.push_back(predict(1'b1, 1'b1, 1'b1, BUF, 1'b1));
        #1;
        sample_and_check("in_reset");
        reset_dut();

        for (int i = 0; i < 5; i++) drive_cycle(1'b0, 1'b0, 1'b0, "idle");

        // Drain all eight credits; full must rise on the 8th debit.
        for (int i = 0; i < BUF; i++) drive_cycle(1'b1, 1'b1, 1'b0, "debit");
        drive_cycle(1'b0, 1'b0, 1'b0, "drained");
        drive_cycle(1'b1, 1'b1, 1'b0, "underflow");
        drive_cycle(1'b1, 1'b0, 1'b0, "not_selected");
        drive_cycle(1'b0, 1'b1, 1'b0, "sel_no_valid");

        // Credit at zero: full_prev holds in the credit cycle.
        drive_cycle(1'b0, 1'b0, 1'b1, "credit_at_zero");
        drive_cycle(1'b0, 1'b0, 1'b0, "after_credit");
        drive_cycle(1'b1, 1'b1, 1'b1, "both_at_one");
        drive_cycle(1'b0, 1'b0, 1'b1, "credit");
        drive_cycle(1'b0, 1'b0, 1'b1, "credit");
        drive_cycle(1'b1, 1'b1, 1'b1, "both_at_three");
        drive_cycle(1'b0, 1'b0, 1'b0, "hold_three");

        for (int i = 0; i < 5; i++) drive_cycle(1'b0, 1'b0, 1'b1, "refill");
        drive_cycle(1'b0, 1'b0, 1'b1, "overflow");
        drive_cycle(1'b1, 1'b1, 1'b1, "both_at_full");
        drive_cycle(1'b0, 1'b0, 1'b0, "full_idle");

        for (int i = 0; i < 300; i++) begin
            drive_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                        1'($urandom_range(0, 1)), "random");
        end

        // Bring the count to 2, then hit reset asynchronously mid-cycle.
        while (model_free > 2) drive_cycle(1'b1, 1'b1, 1'b0, "to_two");
        while (model_free < 2) drive_cycle(1'b0, 1'b0, 1'b1, "to_two");
        @(negedge clk);
        flit_valid = 1'b1;
        flit_sel   = 1'b1;
        cred_valid = 1'b0;
        exp_q.push_back(predict(1'b1, 1'b1, 1'b0, 2, 1'b0));
        #1;
        sample_and_check("pre_async");
        #1;
        reset = 1'b1;
        exp_q.push_back(predict(1'b1, 1'b1, 1'b0, BUF, 1'b1));
        #1;
        sample_and_check("async_reset");
        @(posedge clk);
        #1;
        exp_q.push_back(predict(1'b1, 1'b1, 1'b0, BUF, 1'b1));
        sample_and_check("reset_held");
        reset_dut();
        drive_cycle(1'b1, 1'b1, 1'b0, "first_after_reset");
        drive_cycle(1'b0, 1'b0, 1'b0, "post_reset_idle");

        check_val("queue_drained", 16'(exp_q.size()), 16'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/vcr_ovc_credit_tracker.md
VCR_OVC_CREDIT_TRACKER -- requirements
Module: vcr_ovc_credit_tracker

Interface
REQ-001 Parameter buffer_size, default 8: downstream flit buffer entries (credits) owned by this output VC; legal range 1..256.
REQ-002 Parameter reset_type, default `RESET_TYPE_ASYNC: reset style for all state registers.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high; clears all state immediately, independent of clk.
REQ-005 flit_valid  input  1  a flit leaves the output port this cycle.
REQ-006 flit_sel  input  1  the departing flit belongs to this output VC; driven by the output VC controller.
REQ-007 cred_valid  input  1  downstream router returns one credit for this VC this cycle.
REQ-008 full  output  1  no credits remain once the current flit is counted.
REQ-009 full_prev  output  1  no credits remain, ignoring the current flit.
REQ-010 empty  output  1  all buffer_size credits are home, i.e. the downstream buffer is empty.
REQ-011 errors  output  2  bit 0: credit underflow; bit 1: credit overflow.

Function
REQ-012 State is a single counter, free_q, of width clogb(buffer_size+1); it holds the number of free downstream entries.
REQ-013 Define debit = flit_valid & flit_sel and credit = cred_valid.
REQ-014 Counter update is free_s = free_q - debit + credit, registered on every clock edge where debit | credit; otherwise free_q holds.
REQ-015 Simultaneous debit and credit leave free_q unchanged.
REQ-016 A returned credit takes effect only from the next cycle; it never clears full or full_prev in the cycle it arrives.
REQ-017 full_prev = (free_q == 0); this output depends on registered state only, so that it can gate flit_sel without a combinational loop.
REQ-018 full = (free_q == 0) | ((free_q == 1) & debit).
REQ-019 empty = (free_q == buffer_size); it is registered-state only.
REQ-020 errors[0] is asserted combinationally when debit & (free_q == 0); in that case the counter saturates at 0 instead of wrapping.
REQ-021 errors[1] is asserted combinationally when credit & ~debit & (free_q == buffer_size); in that case the counter saturates at buffer_size.
REQ-022 Errors are not sticky; any aggregation is the router's responsibility.
REQ-023 When buffer_size == 1, full is asserted whenever a flit is debited from the single credit.
REQ-024 Latency: a debit is visible on full in the same cycle, on full_prev and empty the next cycle; a credit is visible on all outputs the next cycle.

Reset
REQ-025 While reset is high, free_q = buffer_size, so full = 0, full_prev = 0, empty = 1 and errors = 2'b00.
REQ-026 A reset asserted mid-operation discards all in-flight accounting; debit and credit inputs are ignored while reset is high.
REQ-027 The first update after reset deasserts occurs on the first clock edge with reset low.

Structure
REQ-028 clogb and the reset-type and elig-mask constants come from the existing shared clib/vcr constant and function includes; the block defines no new typedefs.
REQ-029 The counter is one c_dff instance, with active = debit | credit; no other sub-module is needed.
REQ-030 The router instantiates one tracker per output VC, alongside vcr_ovc_ctrl, and feeds full, full_prev and empty directly into it.

Verification
REQ-031 Reset, then idle 5 cycles -> empty=1, full=0, full_prev=0, errors=0 throughout.
REQ-032 buffer_size=8: 8 consecutive debits -> full=1 in the cycle of the 8th debit; full_prev=1 and empty=0 from the next cycle.
REQ-033 free_q=0, then one credit -> full_prev stays 1 in the credit cycle, becomes 0 the next cycle; free_q=1.
REQ-034 free_q=3, debit and credit in the same cycle -> free_q stays 3, full=0, errors=0.
REQ-035 free_q=0 plus a debit -> errors=2'b01, free_q stays 0; free_q=8 plus a credit with no debit -> errors=2'b10, free_q stays 8.
REQ-036 Assert reset asynchronously mid-cycle at free_q=2 -> outputs return immediately to the reset values of REQ-025.
